// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Provides the sequencer state enum, the bubble instruction and x0 index.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ctrl_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [4:0]  REG_X0   = 5'd0;

  // Per-register hold/bubble bundle, PC first.
  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } stage_ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use detector: an ID operand needs the result of a load sitting in EX.
// In: ID rs1/rs2 addr+used, EX load flag, EX rd. Out: load_use.
module pipe_load_use_det
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd_addr,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;
  logic rd_live;

  assign rs1_hit = id_rs1_used
                 & (id_rs1_addr == ex_rd_addr);
  assign rs2_hit = id_rs2_used
                 & (id_rs2_addr == ex_rd_addr);

  // x0 never carries a produced value.
  assign rd_live = (ex_rd_addr != REG_X0);

  assign load_use = ex_mem_read
                  & rd_live
                  & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
// In: fetch/MMU handshakes, ID operands, EX load/redirect. Out: *_stall, *_flush,
// mem_timeout, perf_*. Param WAIT_TO (0 = no watchdog), CNT_W. Macro PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_TO = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic             mmu_inst_ready,
  input  logic             mem_valid,
  input  logic             mmu_data_ready,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_redirect,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             memwb_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_memw_cnt
);

  localparam int WC_W =
    (WAIT_TO > 1) ? $clog2(WAIT_TO) : 1;
  localparam int WC_LAST_I =
    (WAIT_TO > 0) ? WAIT_TO - 1 : 0;
  localparam logic [WC_W-1:0] WC_LAST =
    WC_W'(WC_LAST_I);
  localparam bit WD_EN = (WAIT_TO > 0);

  ctrl_state_e state_q;
  ctrl_state_e state_d;

  logic load_use;
  logic mem_wait;
  logic fetch_wait;
  logic in_drain;

  logic sel_mw;
  logic sel_rd;
  logic sel_lu;
  logic sel_dr;
  logic sel_fw;

  stage_ctl_t stall;
  stage_ctl_t flush;

  logic [WC_W-1:0] wait_cnt_q;
  logic            to_q;
  logic            to_hit;

  pipe_load_use_det u_lu (
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_mem_read (ex_mem_read),
    .ex_rd_addr  (ex_rd_addr),
    .load_use    (load_use)
  );

  assign mem_wait   = mem_valid & ~mmu_data_ready;
  assign fetch_wait = if_valid & ~mmu_inst_ready;
  assign in_drain   = (state_q == DRAIN);

  // One-hot resolution of the fixed priority chain.
  assign sel_mw = mem_wait;
  assign sel_rd = ~mem_wait & ex_redirect;
  assign sel_lu = ~mem_wait & ~ex_redirect
                & load_use;
  assign sel_dr = ~mem_wait & ~ex_redirect
                & ~load_use & in_drain;
  assign sel_fw = ~mem_wait & ~ex_redirect
                & ~load_use & ~in_drain
                & fetch_wait;

  always_comb begin
    stall   = '0;
    flush   = '0;
    state_d = state_q;
    if (rst) begin
      flush = '1;
    end else begin
      unique case (1'b1)
        sel_mw: begin
          // Whole pipe frozen; redirect and
          // load-use get re-presented later.
          stall = '1;
        end
        sel_rd: begin
          flush.ifid = 1'b1;
          flush.idex = 1'b1;
          // Wrong-path fetch still in flight
          // must be drained before refetch.
          if (fetch_wait) begin
            state_d = DRAIN;
          end
        end
        sel_lu: begin
          stall.pc   = 1'b1;
          stall.ifid = 1'b1;
          flush.idex = 1'b1;
        end
        sel_dr: begin
          stall.pc   = 1'b1;
          flush.ifid = 1'b1;
          // Returning data is wrong-path.
          if (mmu_inst_ready) begin
            state_d = RUN;
          end
        end
        sel_fw: begin
          stall.pc   = 1'b1;
          flush.ifid = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign pc_stall    = stall.pc;
  assign ifid_stall  = stall.ifid;
  assign idex_stall  = stall.idex;
  assign exmem_stall = stall.exmem;
  assign memwb_stall = stall.memwb;

  assign ifid_flush  = flush.ifid;
  assign idex_flush  = flush.idex;
  assign exmem_flush = flush.exmem;
  assign memwb_flush = flush.memwb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Watchdog: counts consecutive MEM-wait
  // cycles and parks at the last value.
  assign to_hit = WD_EN & mem_wait
                & (wait_cnt_q == WC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      to_q       <= 1'b0;
    end else begin
      if (!mem_wait) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != WC_LAST) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (to_hit) begin
        to_q <= 1'b1;
      end
    end
  end

  // Visible in the hitting cycle, then sticky.
  assign mem_timeout = ~rst & (to_q | to_hit);

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] memw_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      memw_cnt_q  <= '0;
    end else begin
      if (stall.pc && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (sel_rd && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
      if (mem_wait && (memw_cnt_q != '1)) begin
        memw_cnt_q <= memw_cnt_q + 1'b1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_memw_cnt  = memw_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
  assign perf_memw_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (WAIT_TO=4).
// Stimulus queues expected controls; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        mmu_inst_ready;
  logic        mem_valid;
  logic        mmu_data_ready;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic        ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic        ex_redirect;
  logic        pc_stall, ifid_stall, idex_stall;
  logic        exmem_stall, memwb_stall;
  logic        ifid_flush, idex_flush;
  logic        exmem_flush, memwb_flush;
  logic        mem_timeout;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_memw_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WAIT_TO(4), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid       (if_valid),
    .mmu_inst_ready (mmu_inst_ready),
    .mem_valid      (mem_valid),
    .mmu_data_ready (mmu_data_ready),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .ex_mem_read    (ex_mem_read),
    .ex_rd_addr     (ex_rd_addr),
    .ex_redirect    (ex_redirect),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .idex_stall     (idex_stall),
    .exmem_stall    (exmem_stall),
    .memwb_stall    (memwb_stall),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .memwb_flush    (memwb_flush),
    .mem_timeout    (mem_timeout),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_memw_cnt  (perf_memw_cnt)
  );

  // {pc,ifid,idex,exmem,memwb stall, ifid,idex,exmem,memwb flush}
  localparam logic [8:0] C_IDLE = 9'b00000_0000;
  localparam logic [8:0] C_RST  = 9'b00000_1111;
  localparam logic [8:0] C_MW   = 9'b11111_0000;
  localparam logic [8:0] C_RD   = 9'b00000_1100;
  localparam logic [8:0] C_LU   = 9'b11000_0100;
  localparam logic [8:0] C_FW   = 9'b10000_1000;

  typedef struct {
    string       name;
    logic [8:0]  ctl;
    logic        to;
    logic        cp;
    logic [31:0] sc;
    logic [31:0] fc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  logic [8:0] ctl;
  assign ctl = {pc_stall, ifid_stall, idex_stall,
                exmem_stall, memwb_stall,
                ifid_flush, idex_flush,
                exmem_flush, memwb_flush};

  function automatic logic [31:0] pexp(int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic chk(input string nm,
                     input logic [8:0] c,
                     input logic t);
    exp_t e;
    e.name = nm; e.ctl = c; e.to = t;
    e.cp = 1'b0; e.sc = 0; e.fc = 0; e.mc = 0;
    q.push_back(e);
  endtask

  task automatic chkp(input string nm,
                      input logic [8:0] c,
                      input logic t,
                      input int s, input int f,
                      input int m);
    exp_t e;
    e.name = nm; e.ctl = c; e.to = t;
    e.cp = 1'b1;
    e.sc = pexp(s); e.fc = pexp(f); e.mc = pexp(m);
    q.push_back(e);
  endtask

  // Monitor: outputs are combinational, so
  // compare mid-cycle against queued entry.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (ctl !== e.ctl) begin
        n_err++;
        $display("FAIL %s ctl got=%b exp=%b",
                 e.name, ctl, e.ctl);
      end
      n_chk++;
      if (mem_timeout !== e.to) begin
        n_err++;
        $display("FAIL %s mem_timeout got=%b exp=%b",
                 e.name, mem_timeout, e.to);
      end
      if (e.cp) begin
        n_chk++;
        if (perf_stall_cnt !== e.sc) begin
          n_err++;
          $display("FAIL %s stall_cnt got=%0d exp=%0d",
                   e.name, perf_stall_cnt, e.sc);
        end
        n_chk++;
        if (perf_flush_cnt !== e.fc) begin
          n_err++;
          $display("FAIL %s flush_cnt got=%0d exp=%0d",
                   e.name, perf_flush_cnt, e.fc);
        end
        n_chk++;
        if (perf_memw_cnt !== e.mc) begin
          n_err++;
          $display("FAIL %s memw_cnt got=%0d exp=%0d",
                   e.name, perf_memw_cnt, e.mc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid       = 1'b0;
    mmu_inst_ready = 1'b0;
    mem_valid      = 1'b0;
    mmu_data_ready = 1'b0;
    id_rs1_addr    = 5'd0;
    id_rs2_addr    = 5'd0;
    id_rs1_used    = 1'b0;
    id_rs2_used    = 1'b0;
    ex_mem_read    = 1'b0;
    ex_rd_addr     = 5'd0;
    ex_redirect    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    chkp("reset", C_RST, 1'b0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd,
                        input logic [4:0] r1,
                        input logic u1,
                        input logic [4:0] r2,
                        input logic u2);
    ex_mem_read = 1'b1;
    ex_rd_addr  = rd;
    id_rs1_addr = r1;
    id_rs1_used = u1;
    id_rs2_addr = r2;
    id_rs2_used = u2;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    do_reset();

    chkp("idle0", C_IDLE, 1'b0, 0, 0, 0);
    tick();

    // MEM wait outranks a pending redirect.
    mem_valid   = 1'b1;
    ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("mw_redir", C_MW, 1'b0);
      tick();
    end
    mmu_data_ready = 1'b1;
    chk("mw_done_redir", C_RD, 1'b0);
    tick();
    idle();

    // Load-use compares.
    set_lu(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
    chk("lu_rs2", C_LU, 1'b0);
    tick();
    set_lu(5'd0, 5'd3, 1'b1, 5'd0, 1'b1);
    chk("lu_x0", C_IDLE, 1'b0);
    tick();
    set_lu(5'd7, 5'd7, 1'b1, 5'd1, 1'b0);
    chk("lu_rs1", C_LU, 1'b0);
    tick();
    set_lu(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
    chk("lu_unused", C_IDLE, 1'b0);
    tick();
    set_lu(5'd7, 5'd7, 1'b1, 5'd1, 1'b0);
    ex_mem_read = 1'b0;
    chk("lu_noload", C_IDLE, 1'b0);
    tick();
    set_lu(5'd9, 5'd9, 1'b1, 5'd1, 1'b0);
    ex_redirect = 1'b1;
    chk("redir_over_lu", C_RD, 1'b0);
    tick();
    idle();

    // Fetch wait, then redirect into DRAIN.
    if_valid = 1'b1;
    chk("fetch_wait", C_FW, 1'b0);
    tick();
    ex_redirect = 1'b1;
    chk("redir_to_drain", C_RD, 1'b0);
    tick();
    if_valid       = 1'b0;
    mmu_inst_ready = 1'b1;
    chk("redir_in_drain", C_RD, 1'b0);
    tick();
    ex_redirect    = 1'b0;
    mmu_inst_ready = 1'b0;
    chk("drain_hold", C_FW, 1'b0);
    tick();
    mmu_inst_ready = 1'b1;
    chk("drain_exit", C_FW, 1'b0);
    tick();
    idle();
    chk("back_run", C_IDLE, 1'b0);
    tick();

    // Watchdog with WAIT_TO=4.
    mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("wd_wait", C_MW, 1'b0);
      tick();
    end
    chk("wd_hit", C_MW, 1'b1);
    tick();
    mem_valid = 1'b0;
    chk("wd_sticky1", C_IDLE, 1'b1);
    tick();
    chk("wd_sticky2", C_IDLE, 1'b1);
    tick();
    do_reset();
    chk("wd_cleared", C_IDLE, 1'b0);
    tick();

    // Reset while draining.
    if_valid    = 1'b1;
    ex_redirect = 1'b1;
    chk("pre_drain", C_RD, 1'b0);
    tick();
    ex_redirect = 1'b0;
    chk("in_drain", C_FW, 1'b0);
    tick();
    do_reset();
    chkp("post_rst_run", C_IDLE, 1'b0, 0, 0, 0);
    tick();

    // Perf: 2 redirects + 3 load-use cycles.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      ex_redirect = 1'b1;
      chk("perf_redir", C_RD, 1'b0);
      tick();
    end
    ex_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
      chk("perf_lu", C_LU, 1'b0);
      tick();
    end
    idle();
    chkp("perf_cnt1", C_IDLE, 1'b0, 3, 2, 0);
    tick();
    mem_valid = 1'b1;
    chk("perf_mw", C_MW, 1'b0);
    tick();
    chk("perf_mw", C_MW, 1'b0);
    tick();
    idle();
    chkp("perf_cnt2", C_IDLE, 1'b0, 5, 2, 2);
    tick();

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_queue left=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
